// File: rtl/sdp_mem_fwd.sv
// sdp_mem_fwd: simple dual-port RAM with lane-masked writes, collision forwarding and 1/2-cycle read latency
module sdp_mem_fwd #(
    parameter int MEM_DATAWIDTH = 128,
    parameter int MEM_ADDRWIDTH = 6,
    parameter int WE_GRAN       = 1,
    parameter int READ_LATENCY  = 1,
    parameter int WRITE_FIRST   = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               ena,
    input  logic [MEM_DATAWIDTH/WE_GRAN-1:0]   wea,
    input  logic [MEM_ADDRWIDTH-1:0]           addra,
    input  logic [MEM_DATAWIDTH-1:0]           dina,
    input  logic                               enb,
    input  logic [MEM_ADDRWIDTH-1:0]           addrb,
    output logic [MEM_DATAWIDTH-1:0]           doutb,
    output logic                               doutb_valid
);
    localparam int LANES = MEM_DATAWIDTH / WE_GRAN;

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("sdp_mem_fwd: READ_LATENCY must be 1 or 2");
    end
    if (MEM_DATAWIDTH % WE_GRAN != 0) begin : g_bad_gran
        $error("sdp_mem_fwd: MEM_DATAWIDTH must be a multiple of WE_GRAN");
    end

    logic [MEM_DATAWIDTH-1:0] mem [2**MEM_ADDRWIDTH];
    logic [MEM_DATAWIDTH-1:0] merged;
    logic [MEM_DATAWIDTH-1:0] rd_q;
    logic                     rd_v;
    logic [MEM_DATAWIDTH-1:0] last_d;
    logic                     last_v;

    always_ff @(posedge clk) begin
        if (!reset && ena)
            for (int k = 0; k < LANES; k++)
                if (wea[k]) mem[addra][k*WE_GRAN +: WE_GRAN] <= dina[k*WE_GRAN +: WE_GRAN];
    end

    // write-first forwards the written lanes of a same-address write into the read word
    always_comb begin
        merged = mem[addrb];
        for (int k = 0; k < LANES; k++)
            if (WRITE_FIRST != 0 && ena && wea[k] && addra == addrb)
                merged[k*WE_GRAN +: WE_GRAN] = dina[k*WE_GRAN +: WE_GRAN];
    end

    assign last_v = (READ_LATENCY == 2) ? rd_v : enb;
    assign last_d = (READ_LATENCY == 2) ? rd_q : merged;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_v        <= 1'b0;
            doutb       <= '0;
            doutb_valid <= 1'b0;
        end else begin
            rd_v        <= enb;
            if (enb) rd_q <= merged;
            doutb_valid <= last_v;
            if (last_v) doutb <= last_d;
        end
    end
endmodule

// File: tb/tb_sdp_mem_fwd.sv
// tb_sdp_mem_fwd: directed checks on three configurations sharing one stimulus bus
module tb_sdp_mem_fwd;
    logic        clk = 1'b0;
    logic        reset;
    logic        ena, enb;
    logic [3:0]  wea8;
    logic [31:0] wea32;
    logic [5:0]  addra, addrb;
    logic [31:0] dina;
    logic [31:0] da, db, dc;
    logic        va, vb, vc;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // a: byte lanes, latency 2, write-first
    sdp_mem_fwd #(.MEM_DATAWIDTH(32), .MEM_ADDRWIDTH(6), .WE_GRAN(8), .READ_LATENCY(2), .WRITE_FIRST(1)) ua (
        .clk(clk), .reset(reset), .ena(ena), .wea(wea8), .addra(addra), .dina(dina),
        .enb(enb), .addrb(addrb), .doutb(da), .doutb_valid(va));
    // b: bit lanes, latency 1, write-first
    sdp_mem_fwd #(.MEM_DATAWIDTH(32), .MEM_ADDRWIDTH(6), .WE_GRAN(1), .READ_LATENCY(1), .WRITE_FIRST(1)) ub (
        .clk(clk), .reset(reset), .ena(ena), .wea(wea32), .addra(addra), .dina(dina),
        .enb(enb), .addrb(addrb), .doutb(db), .doutb_valid(vb));
    // c: bit lanes, latency 1, read-first
    sdp_mem_fwd #(.MEM_DATAWIDTH(32), .MEM_ADDRWIDTH(6), .WE_GRAN(1), .READ_LATENCY(1), .WRITE_FIRST(0)) uc (
        .clk(clk), .reset(reset), .ena(ena), .wea(wea32), .addra(addra), .dina(dina),
        .enb(enb), .addrb(addrb), .doutb(dc), .doutb_valid(vc));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ena = 1'b0; enb = 1'b0; wea8 = '0; wea32 = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; idle(); addra = '0; addrb = '0; dina = '0;
        cyc(); cyc();
        checks++; if (da !== 32'h0) begin errors++; $display("FAIL reset_da got %h want 00000000", da); end
        checks++; if (va !== 1'b0) begin errors++; $display("FAIL reset_va got %b want 0", va); end
        checks++; if (db !== 32'h0) begin errors++; $display("FAIL reset_db got %h want 00000000", db); end
        checks++; if (vb !== 1'b0) begin errors++; $display("FAIL reset_vb got %b want 0", vb); end
        checks++; if (dc !== 32'h0) begin errors++; $display("FAIL reset_dc got %h want 00000000", dc); end
        checks++; if (vc !== 1'b0) begin errors++; $display("FAIL reset_vc got %b want 0", vc); end
        reset = 1'b0;
    endtask

    task automatic test_lane_write();
        ena = 1'b1; addra = 6'd3; dina = 32'hAABBCCDD; wea8 = 4'hF; cyc();
        dina = 32'h11223344; wea8 = 4'b0101; cyc();
        idle(); enb = 1'b1; addrb = 6'd3; cyc();
        checks++; if (va !== 1'b0) begin errors++; $display("FAIL lane_early_valid got %b want 0", va); end
        enb = 1'b0; cyc();
        checks++; if (va !== 1'b1) begin errors++; $display("FAIL lane_valid got %b want 1", va); end
        checks++; if (da !== 32'hAA22CC44) begin errors++; $display("FAIL lane_data got %h want aa22cc44", da); end
        cyc();
        checks++; if (va !== 1'b0) begin errors++; $display("FAIL lane_pulse_end got %b want 0", va); end
        checks++; if (da !== 32'hAA22CC44) begin errors++; $display("FAIL lane_hold got %h want aa22cc44", da); end
    endtask

    task automatic test_collision();
        ena = 1'b1; addra = 6'd5; dina = 32'h0; wea32 = '1; cyc();
        dina = 32'hFFFFFFFF; wea32 = 32'h0000FFFF; enb = 1'b1; addrb = 6'd5; cyc();
        checks++; if (vb !== 1'b1 || db !== 32'h0000FFFF) begin errors++; $display("FAIL coll_wf got %b/%h want 1/0000ffff", vb, db); end
        checks++; if (vc !== 1'b1 || dc !== 32'h00000000) begin errors++; $display("FAIL coll_rf got %b/%h want 1/00000000", vc, dc); end
        idle(); cyc();
        checks++; if (vb !== 1'b0 || db !== 32'h0000FFFF) begin errors++; $display("FAIL coll_hold_b got %b/%h want 0/0000ffff", vb, db); end
        checks++; if (vc !== 1'b0) begin errors++; $display("FAIL coll_hold_c got %b want 0", vc); end
        ena = 1'b1; wea32 = '0; dina = 32'hAAAAAAAA; enb = 1'b1; cyc();
        checks++; if (db !== 32'h0000FFFF) begin errors++; $display("FAIL coll_nowe_b got %h want 0000ffff", db); end
        checks++; if (dc !== 32'h0000FFFF) begin errors++; $display("FAIL coll_nowe_c got %h want 0000ffff", dc); end
        idle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            ena = 1'b1; wea8 = 4'hF; addra = 6'(i); dina = 32'h100 + i; cyc();
        end
        idle();
        for (int i = 0; i < 10; i++) begin
            enb = (i < 8); addrb = 6'(i); cyc();
            checks++; if (va !== (i >= 1 && i <= 8)) begin errors++; $display("FAIL b2b_valid_%0d got %b want %b", i, va, (i >= 1 && i <= 8)); end
            if (i >= 1 && i <= 8) begin
                checks++; if (da !== 32'h100 + i - 1) begin errors++; $display("FAIL b2b_data_%0d got %h want %h", i, da, 32'h100 + i - 1); end
            end
        end
    endtask

    task automatic test_read_then_write();
        ena = 1'b1; wea8 = 4'hF; addra = 6'd9; dina = 32'h5; cyc();
        idle(); enb = 1'b1; addrb = 6'd9; cyc();
        enb = 1'b0; ena = 1'b1; wea8 = 4'hF; addra = 6'd9; dina = 32'h7; cyc();
        checks++; if (va !== 1'b1 || da !== 32'h5) begin errors++; $display("FAIL rtw_old got %b/%h want 1/00000005", va, da); end
        idle(); enb = 1'b1; addrb = 6'd9; cyc();
        enb = 1'b0; cyc();
        checks++; if (va !== 1'b1 || da !== 32'h7) begin errors++; $display("FAIL rtw_new got %b/%h want 1/00000007", va, da); end
    endtask

    task automatic test_reset_flush();
        idle(); enb = 1'b1; addrb = 6'd3; cyc();
        enb = 1'b0; reset = 1'b1; cyc();
        checks++; if (va !== 1'b0 || da !== 32'h0) begin errors++; $display("FAIL flush_r1 got %b/%h want 0/00000000", va, da); end
        enb = 1'b1; addrb = 6'd9; ena = 1'b1; wea8 = 4'hF; addra = 6'd9; dina = 32'h99; cyc();
        checks++; if (va !== 1'b0 || da !== 32'h0) begin errors++; $display("FAIL flush_r2 got %b/%h want 0/00000000", va, da); end
        reset = 1'b0; idle(); cyc();
        checks++; if (va !== 1'b0) begin errors++; $display("FAIL flush_post1 got %b want 0", va); end
        cyc();
        checks++; if (va !== 1'b0) begin errors++; $display("FAIL flush_post2 got %b want 0", va); end
        enb = 1'b1; addrb = 6'd9; cyc();
        enb = 1'b0; cyc();
        checks++; if (va !== 1'b1 || da !== 32'h7) begin errors++; $display("FAIL flush_keep got %b/%h want 1/00000007", va, da); end
    endtask

    task automatic test_wrap();
        ena = 1'b1; wea32 = '1; addra = 6'd63; dina = 32'hDEAD0001; cyc();
        addra = 6'd0; dina = 32'hBEEF0002; cyc();
        idle(); enb = 1'b1; addrb = 6'd63; cyc();
        checks++; if (vb !== 1'b1 || db !== 32'hDEAD0001) begin errors++; $display("FAIL wrap_top_b got %b/%h want 1/dead0001", vb, db); end
        checks++; if (dc !== 32'hDEAD0001) begin errors++; $display("FAIL wrap_top_c got %h want dead0001", dc); end
        addrb = 6'd0; cyc();
        checks++; if (vb !== 1'b1 || db !== 32'hBEEF0002) begin errors++; $display("FAIL wrap_zero_b got %b/%h want 1/beef0002", vb, db); end
        checks++; if (dc !== 32'hBEEF0002) begin errors++; $display("FAIL wrap_zero_c got %h want beef0002", dc); end
        idle(); cyc();
    endtask

    initial begin
        test_reset();
        test_lane_write();
        test_collision();
        test_back_to_back();
        test_read_then_write();
        test_reset_flush();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
